ov7670_frame_writer: RTL and testbench
======================================

// Module: ov7670_frame_writer
// PURPOSE
// - Write side of the RGB565 frame buffer. The VGA driver reads this dual-port RAM; this block fills it.
// - Captures the camera's 8-bit parallel pixel stream (pclk, vsync, href, d) and packs byte pairs into RGB565 words.
// - Writes each word to the RAM write port at address y*640+x, one frame at a time, gated by capture_en.
// PARAMETERS
// - H_ACTIVE      640     pixels per line
// - V_ACTIVE      480     lines per frame
// - ADDR_W        19      RAM address width, must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
// - SYNC_STAGES   2       synchronizer depth on all camera inputs (>=2)
// PORTS
// - CLOCK_50      in   1       system clock; RAM write port is clocked by it too
// - rst_n         in   1       asynchronous, active-low reset
// - capture_en    in   1       level; 1 = capture frames continuously
// - cam_pclk      in   1       camera pixel clock, async, <=12.5 MHz; sampled, never used as a clock
// - cam_vsync     in   1       camera frame sync, active high (high = blanking)
// - cam_href      in   1       camera line valid, active high
// - cam_d         in   8       camera data byte
// - wraddress     out  ADDR_W  RAM write address
// - data          out  16      RAM write data, RGB565 {R[4:0],G[5:0],B[4:0]}
// - wren          out  1       RAM write enable, one-cycle pulse per pixel
// - frame_done    out  1       one-cycle pulse at the end of each captured frame
// - frame_ok      out  1       valid with frame_done: pixel count == H_ACTIVE*V_ACTIVE and no errors
// - busy          out  1       1 while in WAIT_VSYNC or ACTIVE
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, byte phase 0, address 0, error flags 0.
// - Input capture: vsync, href, d and pclk each pass through SYNC_STAGES flops.
//   - pclk_rise = synced pclk is 1 now and was 0 last cycle; all decisions use synced values.
// - FSM states, transitions on CLOCK_50:
//   - IDLE: capture_en=1 -> WAIT_VSYNC.
//   - WAIT_VSYNC: wait for a synced vsync falling edge (frame start).
//     - On that edge: -> ACTIVE; clear address, phase and error flags.
//     - capture_en=0 while waiting -> IDLE.
//   - ACTIVE: capture pixels (below). Synced vsync rising edge -> END.
//   - END: one cycle. Pulse frame_done and drive frame_ok. Then capture_en ? WAIT_VSYNC : IDLE.
// - Capture in ACTIVE, on each pclk_rise with synced href=1:
//   - phase 0: hold d as the high byte, set phase=1.
//   - phase 1: data <= {hi,d}, wren <= 1 on the next cycle, set phase=0.
// - Latency: wren asserts exactly 1 CLOCK_50 cycle after the pclk_rise that completes the pixel.
//   - wraddress holds the pixel address during the pulse.
//   - The address increments in the cycle after the pulse.
// - Address is a linear counter 0..H_ACTIVE*V_ACTIVE-1.
//   - Once it reaches H_ACTIVE*V_ACTIVE, further pixels are suppressed (no wren) and overrun_err is set.
//   - The address never wraps inside a frame.
// - href falling with phase=1 (odd byte count): drop the partial byte, set phase=0, set byte_err.
// - vsync rising while href=1 or phase=1: the frame ends and the partial pixel is discarded with no write.
// - frame_ok = !overrun_err && !byte_err && (address == H_ACTIVE*V_ACTIVE).
// - capture_en dropped during ACTIVE: the current frame completes. The block goes to IDLE after END.
// - rst_n asserted mid-frame: immediate return to IDLE with outputs 0.
//   - After release the block waits for the next vsync falling edge; it never resumes mid-frame.
// - pclk_rise with synced href=0: ignored.
// STRUCTURE
// - Shared package/include vga_cam_defs holds:
//   - constants H_ACTIVE, V_ACTIVE, FRAME_PIXELS and RGB565 field positions
//   - state encoding IDLE/WAIT_VSYNC/ACTIVE/END
//   - the VGA driver uses the same constants.
// - Sub-module cam_input_sync: the SYNC_STAGES synchronizers plus pclk_rise, vsync rise/fall and href fall detection.
// - The top holds the FSM, byte packer, address counter and flags.
// TESTING
// - Camera model on an async pclk (e.g. 12.5 MHz against 50 MHz) drives one full 640x480 frame with byte pairs 0xF8,0x1F:
//   - required: 307200 wren pulses, data 16'hF81F, addresses 0..307199 in order.
//   - required: frame_done pulses once with frame_ok=1.
// - Pixel byte pair 0xAB,0xCD -> data 16'hABCD written 1 cycle after the 2nd-byte pclk_rise.
// - Line with 1281 bytes:
//   - required: 640 writes, last byte dropped, next line starts at phase 0.
//   - required: frame_ok=0 at frame_done.
// - Frame with 481 lines:
//   - required: writes stop at address 307199, no wrap.
//   - required: frame_ok=0.
// - capture_en=0 during ACTIVE -> current frame completes, frame_done pulses, busy=0.
//   - required: no writes on the following frame.
// - rst_n low at pixel 1000, released mid-frame:
//   - required: outputs 0 immediately, no writes until the next vsync falling edge.
//   - required: the next frame starts at address 0.

Source files
------------

// File: rtl/ov7670_frame_writer_pkg.sv
// vga_cam_defs: frame geometry, RGB565 field layout and capture FSM encoding,
// shared between the camera frame writer and the VGA driver.
package vga_cam_defs;
   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int R_LSB = 11, R_W = 5;
   localparam int G_LSB = 5,  G_W = 6;
   localparam int B_LSB = 0,  B_W = 5;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_WAIT   = 2'd1;
   localparam state_t ST_ACTIVE = 2'd2;
   localparam state_t ST_END    = 2'd3;
   typedef struct packed {
      logic       pclk;
      logic       vsync;
      logic       href;
      logic [7:0] d;
   } cam_bus_t;
endpackage

// File: rtl/cam_input_sync.sv
// cam_input_sync: multi-stage synchronizer for the camera bus plus edge
// detection of pclk, vsync and href in the system clock domain.
module cam_input_sync
   import vga_cam_defs::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  cam_bus_t   cam_i,
   output logic       href_o,
   output logic [7:0] d_o,
   output logic       pclk_rise_o,
   output logic       vsync_rise_o,
   output logic       vsync_fall_o,
   output logic       href_fall_o
);
   cam_bus_t sync_q [SYNC_STAGES];
   cam_bus_t cam_s;
   logic     pclk_q, vsync_q, href_q;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         {pclk_q, vsync_q, href_q} <= '0;
      end else begin
         sync_q[0] <= cam_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         {pclk_q, vsync_q, href_q} <= {cam_s.pclk, cam_s.vsync, cam_s.href};
      end
   end
   assign cam_s        = sync_q[SYNC_STAGES-1];
   assign href_o       = cam_s.href;
   assign d_o          = cam_s.d;
   assign pclk_rise_o  = cam_s.pclk & ~pclk_q;
   assign vsync_rise_o = cam_s.vsync & ~vsync_q;
   assign vsync_fall_o = ~cam_s.vsync & vsync_q;
   assign href_fall_o  = ~cam_s.href & href_q;
endmodule

// File: rtl/ov7670_frame_writer.sv
// ov7670_frame_writer: packs the camera byte stream into RGB565 words and
// writes them linearly into the frame buffer, one gated frame at a time.
module ov7670_frame_writer
   import vga_cam_defs::*;
#(
   parameter int H_ACTIVE    = vga_cam_defs::H_ACTIVE,
   parameter int V_ACTIVE    = vga_cam_defs::V_ACTIVE,
   parameter int ADDR_W      = 19,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              capture_en,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_d,
   output logic [ADDR_W-1:0] wraddress,
   output logic [15:0]       data,
   output logic              wren,
   output logic              frame_done,
   output logic              frame_ok,
   output logic              busy
);
   localparam int FRAME = H_ACTIVE * V_ACTIVE;
   // one spare bit so the counter can sit at FRAME without wrapping
   localparam logic [ADDR_W:0] FRAME_C = (ADDR_W+1)'(FRAME);
   logic            href_s, pclk_rise, vsync_rise, vsync_fall, href_fall;
   logic [7:0]      d_s;
   state_t          state_q, state_d;
   logic            phase_q, phase_d;
   logic [7:0]      hi_q, hi_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [15:0]     data_q, data_d;
   logic            wren_q, wren_d;
   logic            ovr_q, ovr_d;
   logic            berr_q, berr_d;
   logic            done_q, ok_q;
   logic            full;
   cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i       (CLOCK_50),
      .rst_n_i     (rst_n),
      .cam_i       ('{pclk: cam_pclk, vsync: cam_vsync, href: cam_href, d: cam_d}),
      .href_o      (href_s),
      .d_o         (d_s),
      .pclk_rise_o (pclk_rise),
      .vsync_rise_o(vsync_rise),
      .vsync_fall_o(vsync_fall),
      .href_fall_o (href_fall)
   );
   assign full = cnt_q == FRAME_C;
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      hi_d    = hi_q;
      cnt_d   = wren_q ? cnt_q + 1'b1 : cnt_q;
      data_d  = data_q;
      wren_d  = 1'b0;
      ovr_d   = ovr_q;
      berr_d  = berr_q;
      case (state_q)
         ST_IDLE: state_d = capture_en ? ST_WAIT : ST_IDLE;
         ST_WAIT: begin
            if (!capture_en) state_d = ST_IDLE;
            else if (vsync_fall) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
               phase_d = 1'b0;
               ovr_d   = 1'b0;
               berr_d  = 1'b0;
            end
         end
         ST_ACTIVE: begin
            // frame end wins over a coinciding byte: any partial pixel is dropped
            if (vsync_rise) begin
               state_d = ST_END;
               phase_d = 1'b0;
            end else if (href_fall && phase_q) begin
               phase_d = 1'b0;
               berr_d  = 1'b1;
            end else if (pclk_rise && href_s) begin
               phase_d = ~phase_q;
               hi_d    = phase_q ? hi_q : d_s;
               if (phase_q && full) ovr_d = 1'b1;
               if (phase_q && !full) begin
                  wren_d = 1'b1;
                  data_d = {hi_q, d_s};
               end
            end
         end
         default: state_d = capture_en ? ST_WAIT : ST_IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= 1'b0;
         hi_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         wren_q  <= 1'b0;
         ovr_q   <= 1'b0;
         berr_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         wren_q  <= wren_d;
         ovr_q   <= ovr_d;
         berr_q  <= berr_d;
         done_q  <= state_q == ST_END;
         ok_q    <= state_q == ST_END && !ovr_q && !berr_q && full;
      end
   end
   assign wraddress  = cnt_q[ADDR_W-1:0];
   assign data       = data_q;
   assign wren       = wren_q;
   assign frame_done = done_q;
   assign frame_ok   = ok_q;
   assign busy       = state_q == ST_WAIT || state_q == ST_ACTIVE;
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// tb_ov7670_frame_writer: directed camera frames on a reduced 8x4 geometry,
// with pclk at 12.5 MHz held 3 ns ahead of the 50 MHz sampling edges.
module tb_ov7670_frame_writer;
   localparam int H = 8, V = 4, AW = 5, FRAME = H * V;
   logic          CLOCK_50 = 1'b0, rst_n = 1'b0, capture_en = 1'b0;
   logic          cam_pclk = 1'b0, cam_vsync = 1'b1, cam_href = 1'b0;
   logic [7:0]    cam_d = 8'h00;
   logic [AW-1:0] wraddress;
   logic [15:0]   data;
   logic          wren, frame_done, frame_ok, busy;
   int            nvec = 0, nfail = 0, nw = 0, nd = 0;
   logic          last_ok = 1'b0;
   int            wa [256];
   logic [15:0]   wd [256];
   time           wt [256];
   ov7670_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
      .CLOCK_50  (CLOCK_50),
      .rst_n     (rst_n),
      .capture_en(capture_en),
      .cam_pclk  (cam_pclk),
      .cam_vsync (cam_vsync),
      .cam_href  (cam_href),
      .cam_d     (cam_d),
      .wraddress (wraddress),
      .data      (data),
      .wren      (wren),
      .frame_done(frame_done),
      .frame_ok  (frame_ok),
      .busy      (busy)
   );
   always #10 CLOCK_50 = ~CLOCK_50;
   initial begin
      #7;
      forever #40 cam_pclk = ~cam_pclk;
   end
   always @(negedge CLOCK_50) begin
      if (wren && nw < 256) begin
         wa[nw] = int'(wraddress);
         wd[nw] = data;
         wt[nw] = $time;
         nw++;
      end
      if (frame_done) begin
         nd++;
         last_ok = frame_ok;
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic check_run(input string tag, input int b, input int n, input logic [15:0] exp_d);
      int bad = 0;
      for (int i = 0; i < n; i++) if (wa[b+i] != i || wd[b+i] !== exp_d) bad++;
      check(tag, 32'(bad), 32'd0);
   endtask
   task automatic settle(input int n);
      repeat (n) @(negedge CLOCK_50);
      #1;
   endtask
   task automatic send_byte(input logic [7:0] b);
      @(negedge cam_pclk);
      cam_d = b;
      cam_href = 1'b1;
   endtask
   task automatic end_line();
      @(negedge cam_pclk);
      cam_href = 1'b0;
      repeat (3) @(negedge cam_pclk);
   endtask
   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) send_byte(i[0] ? 8'h1F : 8'hF8);
      end_line();
   endtask
   task automatic vs_fall();
      @(negedge cam_pclk);
      cam_vsync = 1'b0;
      repeat (3) @(negedge cam_pclk);
   endtask
   task automatic vs_rise();
      @(negedge cam_pclk);
      cam_vsync = 1'b1;
      repeat (4) @(negedge cam_pclk);
   endtask
   task automatic frame(input int lines);
      vs_fall();
      repeat (lines) send_line(2 * H);
      vs_rise();
   endtask
   initial begin
      int  b, b2, d0;
      time tp;
      settle(3);
      check("rst_wren", 32'(wren), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_addr", 32'(wraddress), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_ok", 32'(frame_ok), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      capture_en = 1'b1;
      settle(3);
      check("wait_busy", 32'(busy), 32'd1);
      // full frame of 0xF8,0x1F pairs
      b = nw; d0 = nd;
      frame(V);
      check("full_count", 32'(nw - b), 32'(FRAME));
      check_run("full_order", b, nw - b, 16'hF81F);
      check("full_done", 32'(nd - d0), 32'd1);
      check("full_ok", 32'(last_ok), 32'd1);
      // single pixel 0xAB,0xCD: write lands 3 ns + 2 sync stages + 1 register + half cycle after the pclk edge
      b = nw; d0 = nd;
      vs_fall();
      send_byte(8'hAB);
      send_byte(8'hCD);
      @(posedge cam_pclk);
      tp = $time;
      end_line();
      vs_rise();
      check("pix_count", 32'(nw - b), 32'd1);
      check("pix_data", 32'(wd[b]), 32'h0000ABCD);
      check("pix_addr", 32'(wa[b]), 32'd0);
      check("pix_latency", 32'(wt[b] - tp), 32'd53);
      check("pix_ok", 32'(last_ok), 32'd0);
      // first line carries one extra byte
      b = nw; d0 = nd;
      vs_fall();
      send_line(2 * H + 1);
      repeat (V - 1) send_line(2 * H);
      vs_rise();
      check("odd_count", 32'(nw - b), 32'(FRAME));
      check_run("odd_order", b, nw - b, 16'hF81F);
      check("odd_done", 32'(nd - d0), 32'd1);
      check("odd_ok", 32'(last_ok), 32'd0);
      // one line too many
      b = nw; d0 = nd;
      frame(V + 1);
      check("ovr_count", 32'(nw - b), 32'(FRAME));
      check_run("ovr_order", b, nw - b, 16'hF81F);
      check("ovr_last_addr", 32'(wa[nw-1]), 32'(FRAME - 1));
      check("ovr_done", 32'(nd - d0), 32'd1);
      check("ovr_ok", 32'(last_ok), 32'd0);
      // capture_en dropped mid-frame
      b = nw; d0 = nd;
      vs_fall();
      repeat (2) send_line(2 * H);
      capture_en = 1'b0;
      repeat (V - 2) send_line(2 * H);
      vs_rise();
      check("cen_count", 32'(nw - b), 32'(FRAME));
      check("cen_done", 32'(nd - d0), 32'd1);
      check("cen_ok", 32'(last_ok), 32'd1);
      settle(2);
      check("cen_busy", 32'(busy), 32'd0);
      b = nw; d0 = nd;
      frame(V);
      check("cen_next_count", 32'(nw - b), 32'd0);
      check("cen_next_done", 32'(nd - d0), 32'd0);
      // reset after pixel 10, released mid-frame
      capture_en = 1'b1;
      settle(3);
      b = nw; d0 = nd;
      vs_fall();
      for (int i = 0; i < 2 * H + 4; i++) send_byte(i[0] ? 8'h1F : 8'hF8);
      @(posedge cam_pclk);
      settle(4);
      check("prerst_count", 32'(nw - b), 32'd10);
      rst_n = 1'b0;
      #1;
      check("midrst_wren", 32'(wren), 32'd0);
      check("midrst_data", 32'(data), 32'd0);
      check("midrst_addr", 32'(wraddress), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      settle(2);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * H - 4; i++) send_byte(i[0] ? 8'h1F : 8'hF8);
      end_line();
      repeat (2) send_line(2 * H);
      vs_rise();
      check("postrst_count", 32'(nw - b), 32'd10);
      check("postrst_done", 32'(nd - d0), 32'd0);
      b2 = nw; d0 = nd;
      frame(V);
      check("resume_count", 32'(nw - b2), 32'(FRAME));
      check("resume_first_addr", 32'(wa[b2]), 32'd0);
      check_run("resume_order", b2, nw - b2, 16'hF81F);
      check("resume_ok", 32'(last_ok), 32'd1);
      check("resume_done", 32'(nd - d0), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
